decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// Single-entry instruction decode stage with ready/valid handshake and a saturating illegal counter.
// Optional macro DECODE_MEXT_EN: accept R-type funct7=0000001 (M extension) and raise mext.
module decode_stage #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic            clock,
    input  logic            nreset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [PC_W-1:0] pc_in,
    output logic            out_valid,
    input  logic            out_ready,
    input  logic            flush,
    output logic [3:0]      alu_op,
    output logic            regw,
    output logic            memr,
    output logic            memw,
    output logic            branch,
    output logic            jump,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] imm,
    output logic [PC_W-1:0] pc_out,
    output logic            illegal,
    output logic            mext,
    output logic [15:0]     illegal_count
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1_f, rs2_f, rd_f;
    logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    logic [3:0]      alu_op_d;
    logic            regw_d, memr_d, memw_d, branch_d, jump_d, illegal_d, mext_d;
    logic [4:0]      rs1_d, rs2_d, rd_d;
    logic signed [31:0] imm32_d;
    logic [XLEN-1:0] imm_d;

    logic            out_valid_q;
    logic [3:0]      alu_op_q;
    logic            regw_q, memr_q, memw_q, branch_q, jump_q, illegal_q, mext_q;
    logic [4:0]      rs1_q, rs2_q, rd_q;
    logic [XLEN-1:0] imm_q;
    logic [PC_W-1:0] pc_q;
    logic [15:0]     illegal_count_q;

    logic accept;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign rs1_f  = instr[19:15];
    assign rs2_f  = instr[24:20];
    assign rd_f   = instr[11:7];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'h000};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Every field a format does not use stays at its zero default, including all fields of an illegal word.
    always_comb begin
        alu_op_d  = 4'b0000;
        regw_d    = 1'b0;
        memr_d    = 1'b0;
        memw_d    = 1'b0;
        branch_d  = 1'b0;
        jump_d    = 1'b0;
        illegal_d = 1'b0;
        mext_d    = 1'b0;
        rs1_d     = 5'd0;
        rs2_d     = 5'd0;
        rd_d      = 5'd0;
        imm32_d   = 32'sd0;
        case (opcode)
            OP_R: begin
                if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
                    alu_op_d = {funct3, funct7[5]};
                    regw_d   = 1'b1;
                    rs1_d    = rs1_f;
                    rs2_d    = rs2_f;
                    rd_d     = rd_f;
`ifdef DECODE_MEXT_EN
                end else if (funct7 == 7'b0000001) begin
                    alu_op_d = {funct3, 1'b0};
                    regw_d   = 1'b1;
                    mext_d   = 1'b1;
                    rs1_d    = rs1_f;
                    rs2_d    = rs2_f;
                    rd_d     = rd_f;
`endif
                end else begin
                    illegal_d = 1'b1;
                end
            end
            OP_I: begin
                alu_op_d = {funct3, (funct3 == 3'b101) ? funct7[5] : 1'b0};
                regw_d   = 1'b1;
                rs1_d    = rs1_f;
                rd_d     = rd_f;
                imm32_d  = imm_i;
            end
            OP_LOAD: begin
                memr_d  = 1'b1;
                regw_d  = 1'b1;
                rs1_d   = rs1_f;
                rd_d    = rd_f;
                imm32_d = imm_i;
            end
            OP_STORE: begin
                memw_d  = 1'b1;
                rs1_d   = rs1_f;
                rs2_d   = rs2_f;
                imm32_d = imm_s;
            end
            OP_BRANCH: begin
                alu_op_d = 4'b0001;
                branch_d = 1'b1;
                rs1_d    = rs1_f;
                rs2_d    = rs2_f;
                imm32_d  = imm_b;
            end
            OP_LUI, OP_AUIPC: begin
                regw_d  = 1'b1;
                rd_d    = rd_f;
                imm32_d = imm_u;
            end
            OP_JAL: begin
                jump_d  = 1'b1;
                regw_d  = 1'b1;
                rd_d    = rd_f;
                imm32_d = imm_j;
            end
            OP_JALR: begin
                jump_d  = 1'b1;
                regw_d  = 1'b1;
                rs1_d   = rs1_f;
                rd_d    = rd_f;
                imm32_d = imm_i;
            end
            default: begin
                illegal_d = 1'b1;
            end
        endcase
    end

    // Signed cast sign-extends from bit 31 for XLEN=64 and is a plain copy for XLEN=32.
    assign imm_d = XLEN'(imm32_d);

    assign in_ready = !flush && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clock) begin
        if (!nreset) begin
            out_valid_q <= 1'b0;
            alu_op_q    <= 4'b0000;
            regw_q      <= 1'b0;
            memr_q      <= 1'b0;
            memw_q      <= 1'b0;
            branch_q    <= 1'b0;
            jump_q      <= 1'b0;
            illegal_q   <= 1'b0;
            mext_q      <= 1'b0;
            rs1_q       <= 5'd0;
            rs2_q       <= 5'd0;
            rd_q        <= 5'd0;
            imm_q       <= '0;
            pc_q        <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            alu_op_q    <= alu_op_d;
            regw_q      <= regw_d;
            memr_q      <= memr_d;
            memw_q      <= memw_d;
            branch_q    <= branch_d;
            jump_q      <= jump_d;
            illegal_q   <= illegal_d;
            mext_q      <= mext_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            imm_q       <= imm_d;
            pc_q        <= pc_in;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // accept already excludes flush cycles, so discarded words never count.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            illegal_count_q <= 16'h0000;
        end else if (accept && illegal_d && illegal_count_q != 16'hFFFF) begin
            illegal_count_q <= illegal_count_q + 16'h0001;
        end
    end

    assign out_valid     = out_valid_q;
    assign alu_op        = alu_op_q;
    assign regw          = regw_q;
    assign memr          = memr_q;
    assign memw          = memw_q;
    assign branch        = branch_q;
    assign jump          = jump_q;
    assign rs1           = rs1_q;
    assign rs2           = rs2_q;
    assign rd            = rd_q;
    assign imm           = imm_q;
    assign pc_out        = pc_q;
    assign illegal       = illegal_q;
    assign mext          = mext_q;
    assign illegal_count = illegal_count_q;

endmodule
